// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch slice.
//   XLEN / INST_WIDTH : address and instruction widths
//   RESET_PC_DEFAULT  : default fetch PC after reset
//   fetch_entry_t     : one buffered {pc, inst} pair as stored in the fetch FIFO
package inst_fetch_unit_pkg;

  localparam int XLEN       = 32;
  localparam int INST_WIDTH = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]       pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Synchronous DEPTH-entry FIFO of fetch_entry_t.
//   CLK, RST     : clock, synchronous active-high reset
//   push / wdata : enqueue (accepted when not full, or when full and popping)
//   pop          : dequeue head (ignored when empty)
//   flush        : drop all entries; overrides push and pop
//   rdata        : head entry (undefined contents when empty)
//   full / empty : from pointer compare, pointers carry one extra wrap bit
module inst_fetch_unit_fetch_fifo
  import inst_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]  wr_ptr, rd_ptr;
  fetch_entry_t mem [DEPTH];
  logic         do_push, do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop && !empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);

  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // storage needs no reset: the head is only observed when non-empty
  always_ff @(posedge CLK) begin
    if (!RST && !flush && do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, reads the memory instruction port
// combinationally, buffers {pc, inst} pairs and hands them to decode via valid/ready.
//   CLK, RST                : clock, synchronous active-high reset
//   InstAddr / InstIn       : memory instruction port (address out, word back same cycle)
//   RedirValid / RedirPC    : branch/jump redirect, flushes the buffer
//   HaltIn                  : sticky stop of fetching (buffer still drains)
//   OutReady/OutValid/OutPC/OutInst : head-of-buffer handshake to decode
//   Fault / FaultPC         : sticky misaligned-redirect or out-of-range fetch
//   FetchCount              : words pushed since reset (wraps)
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              MEM_BYTES = 1024,
  parameter int              DEPTH     = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic [XLEN-1:0]       InstAddr,
  input  logic [INST_WIDTH-1:0] InstIn,
  input  logic                  RedirValid,
  input  logic [XLEN-1:0]       RedirPC,
  input  logic                  HaltIn,
  input  logic                  OutReady,
  output logic                  OutValid,
  output logic [XLEN-1:0]       OutPC,
  output logic [INST_WIDTH-1:0] OutInst,
  output logic                  Fault,
  output logic [XLEN-1:0]       FaultPC,
  output logic [31:0]           FetchCount
);

  // last address whose full 4-byte word lies inside memory
  localparam logic [XLEN-1:0] LAST_PC = XLEN'(MEM_BYTES - 4);

  logic [XLEN-1:0] fetch_pc;
  logic            halted;
  logic            fifo_full, fifo_empty;
  logic            pop, fetch_en, range_bad, push;
  fetch_entry_t    head, wr_entry;

  assign InstAddr = fetch_pc;

  assign pop       = OutValid && OutReady;
  assign fetch_en  = !halted && !HaltIn && !Fault && !RedirValid && (!fifo_full || pop);
  assign range_bad = (fetch_pc > LAST_PC);
  assign push      = fetch_en && !range_bad;

  assign wr_entry = '{pc: fetch_pc, inst: InstIn};

  inst_fetch_unit_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push),
    .wdata (wr_entry),
    .pop   (pop),
    .flush (RedirValid),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // head fields read as zero while nothing is buffered
  assign OutValid = !fifo_empty;
  assign OutPC    = fifo_empty ? '0 : head.pc;
  assign OutInst  = fifo_empty ? '0 : head.inst;

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetch_pc   <= RESET_PC;
      halted     <= 1'b0;
      Fault      <= 1'b0;
      FaultPC    <= '0;
      FetchCount <= '0;
    end else begin
      if (HaltIn) halted <= 1'b1;
      if (RedirValid) begin
        // once faulted, a redirect only flushes the buffer
        if (!Fault) begin
          if (RedirPC[1:0] == 2'b00) begin
            fetch_pc <= RedirPC;
          end else begin
            Fault   <= 1'b1;
            FaultPC <= RedirPC;
          end
        end
      end else if (fetch_en) begin
        if (range_bad) begin
          Fault   <= 1'b1;
          FaultPC <= fetch_pc;
        end else begin
          fetch_pc   <= fetch_pc + 32'd4;
          FetchCount <= FetchCount + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a < 32'd16) return 32'h0000_0013;
    return {16'hC0DE, a[15:0]};
  endfunction

  // DUT A: default parameters
  logic        rst, redir, halt, ready;
  logic [31:0] rpc;
  logic [31:0] addr, inst_in, opc, oinst, fpc, cnt;
  logic        ovalid, fault;
  assign inst_in = memw(addr);

  inst_fetch_unit dut (
    .CLK(CLK), .RST(rst), .InstAddr(addr), .InstIn(inst_in),
    .RedirValid(redir), .RedirPC(rpc), .HaltIn(halt), .OutReady(ready),
    .OutValid(ovalid), .OutPC(opc), .OutInst(oinst),
    .Fault(fault), .FaultPC(fpc), .FetchCount(cnt)
  );

  // DUT B: starts two words before the end of memory
  logic        b_rst, b_redir, b_halt, b_ready;
  logic [31:0] b_rpc;
  logic [31:0] b_addr, b_inst_in, b_opc, b_oinst, b_fpc, b_cnt;
  logic        b_ovalid, b_fault;
  assign b_inst_in = memw(b_addr);

  inst_fetch_unit #(.RESET_PC(32'h0000_03F8), .MEM_BYTES(1024), .DEPTH(2)) dut_b (
    .CLK(CLK), .RST(b_rst), .InstAddr(b_addr), .InstIn(b_inst_in),
    .RedirValid(b_redir), .RedirPC(b_rpc), .HaltIn(b_halt), .OutReady(b_ready),
    .OutValid(b_ovalid), .OutPC(b_opc), .OutInst(b_oinst),
    .Fault(b_fault), .FaultPC(b_fpc), .FetchCount(b_cnt)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    bit          rst, redir, halt, ready;
    logic [31:0] rpc;
    bit          ev, ef;
    logic [31:0] epc, einst, efpc, ecnt, eaddr;
  } vec_t;

  function automatic vec_t v(bit r, bit rd, logic [31:0] rp, bit h, bit rdy,
                             bit ev, logic [31:0] epc, logic [31:0] ei, bit ef,
                             logic [31:0] efp, logic [31:0] ec, logic [31:0] ea);
    vec_t x;
    x.rst = r; x.redir = rd; x.rpc = rp; x.halt = h; x.ready = rdy;
    x.ev = ev; x.epc = epc; x.einst = ei; x.ef = ef; x.efpc = efp; x.ecnt = ec; x.eaddr = ea;
    return x;
  endfunction

  // reference model state
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_pc, m_fpc, m_cnt;
  bit          m_halt, m_fault;

  task automatic model_step(input bit r, input bit rd, input logic [31:0] rp,
                            input bit h, input bit rdy);
    bit pop, can;
    if (r) begin
      m_q.delete(); m_pc = 32'h0; m_fpc = 32'h0; m_cnt = 32'h0; m_halt = 0; m_fault = 0;
      return;
    end
    pop = (m_q.size() > 0) && rdy;
    can = !m_halt && !h && !m_fault && !rd && ((m_q.size() < 2) || pop);
    if (rd) begin
      m_q.delete();
      if (!m_fault) begin
        if (rp % 4 == 0) m_pc = rp;
        else begin m_fault = 1; m_fpc = rp; end
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (can) begin
        if (m_pc + 32'd4 > 32'd1024) begin m_fault = 1; m_fpc = m_pc; end
        else begin
          m_q.push_back('{pc: m_pc, inst: memw(m_pc)});
          m_pc = m_pc + 32'd4;
          m_cnt = m_cnt + 32'd1;
        end
      end
    end
    if (h) m_halt = 1;
  endtask

  vec_t vecs[33];

  task automatic step_b(input bit r, input bit rdy);
    b_rst = r; b_ready = rdy;
    @(posedge CLK); #1;
  endtask

  initial begin
    rst = 1; redir = 0; halt = 0; ready = 0; rpc = 0;
    b_rst = 1; b_redir = 0; b_halt = 0; b_ready = 0; b_rpc = 0;

    //            rst rd rpc      h rdy  ev pc        inst           f fpc    cnt addr
    vecs[0]  = v(1, 0, 0,        0, 0,  0, 0,        0,             0, 0,     0, 0);
    vecs[1]  = v(0, 0, 0,        0, 1,  1, 0,        32'h13,        0, 0,     1, 32'h4);
    vecs[2]  = v(0, 0, 0,        0, 1,  1, 32'h4,    32'h13,        0, 0,     2, 32'h8);
    vecs[3]  = v(0, 0, 0,        0, 1,  1, 32'h8,    32'h13,        0, 0,     3, 32'hC);
    vecs[4]  = v(0, 0, 0,        0, 1,  1, 32'hC,    32'h13,        0, 0,     4, 32'h10);
    vecs[5]  = v(0, 0, 0,        0, 0,  1, 32'hC,    32'h13,        0, 0,     5, 32'h14);
    vecs[6]  = v(0, 0, 0,        0, 0,  1, 32'hC,    32'h13,        0, 0,     5, 32'h14);
    vecs[7]  = v(0, 0, 0,        0, 0,  1, 32'hC,    32'h13,        0, 0,     5, 32'h14);
    vecs[8]  = v(0, 0, 0,        0, 0,  1, 32'hC,    32'h13,        0, 0,     5, 32'h14);
    vecs[9]  = v(0, 0, 0,        0, 0,  1, 32'hC,    32'h13,        0, 0,     5, 32'h14);
    vecs[10] = v(0, 0, 0,        0, 1,  1, 32'h10,   32'hC0DE0010,  0, 0,     6, 32'h18);
    vecs[11] = v(0, 0, 0,        0, 1,  1, 32'h14,   32'hC0DE0014,  0, 0,     7, 32'h1C);
    vecs[12] = v(0, 1, 32'h40,   0, 1,  0, 0,        0,             0, 0,     7, 32'h40);
    vecs[13] = v(0, 0, 0,        0, 0,  1, 32'h40,   32'hC0DE0040,  0, 0,     8, 32'h44);
    vecs[14] = v(0, 0, 0,        0, 0,  1, 32'h40,   32'hC0DE0040,  0, 0,     9, 32'h48);
    vecs[15] = v(0, 1, 32'h42,   0, 0,  0, 0,        0,             1, 32'h42, 9, 32'h48);
    vecs[16] = v(0, 0, 0,        0, 1,  0, 0,        0,             1, 32'h42, 9, 32'h48);
    vecs[17] = v(0, 0, 0,        0, 1,  0, 0,        0,             1, 32'h42, 9, 32'h48);
    vecs[18] = v(0, 1, 32'h80,   0, 1,  0, 0,        0,             1, 32'h42, 9, 32'h48);
    vecs[19] = v(1, 0, 0,        0, 0,  0, 0,        0,             0, 0,     0, 0);
    vecs[20] = v(0, 0, 0,        0, 0,  1, 0,        32'h13,        0, 0,     1, 32'h4);
    vecs[21] = v(0, 0, 0,        0, 0,  1, 0,        32'h13,        0, 0,     2, 32'h8);
    vecs[22] = v(0, 0, 0,        1, 0,  1, 0,        32'h13,        0, 0,     2, 32'h8);
    vecs[23] = v(0, 0, 0,        0, 1,  1, 32'h4,    32'h13,        0, 0,     2, 32'h8);
    vecs[24] = v(0, 0, 0,        0, 1,  0, 0,        0,             0, 0,     2, 32'h8);
    vecs[25] = v(0, 0, 0,        0, 1,  0, 0,        0,             0, 0,     2, 32'h8);
    vecs[26] = v(0, 1, 32'h40,   0, 1,  0, 0,        0,             0, 0,     2, 32'h40);
    vecs[27] = v(0, 0, 0,        0, 1,  0, 0,        0,             0, 0,     2, 32'h40);
    vecs[28] = v(1, 0, 0,        0, 0,  0, 0,        0,             0, 0,     0, 0);
    vecs[29] = v(0, 0, 0,        0, 0,  1, 0,        32'h13,        0, 0,     1, 32'h4);
    vecs[30] = v(0, 0, 0,        0, 0,  1, 0,        32'h13,        0, 0,     2, 32'h8);
    vecs[31] = v(1, 1, 32'h42,   1, 1,  0, 0,        0,             0, 0,     0, 0);
    vecs[32] = v(0, 0, 0,        0, 0,  1, 0,        32'h13,        0, 0,     1, 32'h4);

    for (int i = 0; i < 33; i++) begin
      rst = vecs[i].rst; redir = vecs[i].redir; rpc = vecs[i].rpc;
      halt = vecs[i].halt; ready = vecs[i].ready;
      @(posedge CLK); #1;
      chk($sformatf("vec%0d valid", i), {31'b0, ovalid}, {31'b0, vecs[i].ev});
      chk($sformatf("vec%0d pc", i),    opc,   vecs[i].epc);
      chk($sformatf("vec%0d inst", i),  oinst, vecs[i].einst);
      chk($sformatf("vec%0d fault", i), {31'b0, fault}, {31'b0, vecs[i].ef});
      chk($sformatf("vec%0d fpc", i),   fpc,   vecs[i].efpc);
      chk($sformatf("vec%0d cnt", i),   cnt,   vecs[i].ecnt);
      chk($sformatf("vec%0d addr", i),  addr,  vecs[i].eaddr);
    end

    // end-of-memory range fault on DUT B
    step_b(1, 0);
    chk("end reset valid", {31'b0, b_ovalid}, 32'h0);
    chk("end reset addr", b_addr, 32'h3F8);
    step_b(0, 0);
    chk("end push1 pc", b_opc, 32'h3F8);
    chk("end push1 inst", b_oinst, 32'hC0DE03F8);
    chk("end push1 cnt", b_cnt, 32'h1);
    step_b(0, 0);
    chk("end push2 cnt", b_cnt, 32'h2);
    chk("end push2 addr", b_addr, 32'h400);
    step_b(0, 0);
    chk("end full no fault", {31'b0, b_fault}, 32'h0);
    step_b(0, 1);
    chk("end fault", {31'b0, b_fault}, 32'h1);
    chk("end fault pc", b_fpc, 32'h400);
    chk("end drain head", b_opc, 32'h3FC);
    chk("end drain valid", {31'b0, b_ovalid}, 32'h1);
    step_b(0, 1);
    chk("end drained", {31'b0, b_ovalid}, 32'h0);
    chk("end cnt frozen", b_cnt, 32'h2);
    step_b(0, 1);
    chk("end stays faulted", {31'b0, b_fault}, 32'h1);

    // randomized run of DUT A against the reference model
    for (int c = 0; c < 3000; c++) begin
      int sel;
      rst   = (c == 0) || ($urandom_range(0, 99) < 2);
      redir = ($urandom_range(0, 99) < 10);
      halt  = ($urandom_range(0, 99) < 2);
      ready = ($urandom_range(0, 99) < 70);
      sel   = $urandom_range(0, 9);
      if (sel < 6)       rpc = 32'($urandom_range(0, 255)) * 32'd4;
      else if (sel < 8)  rpc = 32'h3F0 + 32'($urandom_range(0, 3)) * 32'd4;
      else if (sel == 8) rpc = 32'($urandom_range(0, 255)) * 32'd4 + 32'($urandom_range(1, 3));
      else               rpc = 32'h400 + 32'($urandom_range(0, 15)) * 32'd4;
      model_step(rst, redir, rpc, halt, ready);
      @(posedge CLK); #1;
      chk($sformatf("rand%0d valid", c), {31'b0, ovalid}, {31'b0, m_q.size() > 0});
      chk($sformatf("rand%0d pc", c),   opc,   (m_q.size() > 0) ? m_q[0].pc   : 32'h0);
      chk($sformatf("rand%0d inst", c), oinst, (m_q.size() > 0) ? m_q[0].inst : 32'h0);
      chk($sformatf("rand%0d fault", c), {31'b0, fault}, {31'b0, m_fault});
      chk($sformatf("rand%0d fpc", c),  fpc,  m_fpc);
      chk($sformatf("rand%0d cnt", c),  cnt,  m_cnt);
      chk($sformatf("rand%0d addr", c), addr, m_pc);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
